// File: rtl/caravel.sv
// Caravel-style JTAG TAP: synchronized TCK/TMS/TDI, 4-bit IR, IDCODE/BYPASS/USER data registers.
// Define CARAVEL_USER_DR_EN to enable the USER instruction and the writable user_reg.
module caravel #(
  parameter logic [31:0] IDCODE = 32'h14D57048
) (
  input  logic        clock,
  input  logic        resetb,
  input  logic [37:0] mprj_io_in,
  output logic [37:0] mprj_io_out,
  output logic [37:0] mprj_io_oeb,
  output logic [31:0] user_reg
);

  localparam logic [3:0] IR_IDCODE  = 4'b0001;
  localparam logic [3:0] IR_USER    = 4'b0010;
  localparam logic [3:0] IR_CAPTURE = 4'b0101;

  typedef enum logic [3:0] {
    TLR, RTI,
    SEL_DR, CAP_DR, SHIFT_DR, EXIT1_DR, PAUSE_DR, EXIT2_DR, UPD_DR,
    SEL_IR, CAP_IR, SHIFT_IR, EXIT1_IR, PAUSE_IR, EXIT2_IR, UPD_IR
  } tap_state_t;

  function automatic tap_state_t tap_next(input tap_state_t s, input logic tms);
    case (s)
      TLR:      tap_next = tms ? TLR      : RTI;
      RTI:      tap_next = tms ? SEL_DR   : RTI;
      SEL_DR:   tap_next = tms ? SEL_IR   : CAP_DR;
      CAP_DR:   tap_next = tms ? EXIT1_DR : SHIFT_DR;
      SHIFT_DR: tap_next = tms ? EXIT1_DR : SHIFT_DR;
      EXIT1_DR: tap_next = tms ? UPD_DR   : PAUSE_DR;
      PAUSE_DR: tap_next = tms ? EXIT2_DR : PAUSE_DR;
      EXIT2_DR: tap_next = tms ? UPD_DR   : SHIFT_DR;
      UPD_DR:   tap_next = tms ? SEL_DR   : RTI;
      SEL_IR:   tap_next = tms ? TLR      : CAP_IR;
      CAP_IR:   tap_next = tms ? EXIT1_IR : SHIFT_IR;
      SHIFT_IR: tap_next = tms ? EXIT1_IR : SHIFT_IR;
      EXIT1_IR: tap_next = tms ? UPD_IR   : PAUSE_IR;
      PAUSE_IR: tap_next = tms ? EXIT2_IR : PAUSE_IR;
      EXIT2_IR: tap_next = tms ? UPD_IR   : SHIFT_IR;
      default:  tap_next = tms ? SEL_DR   : RTI;
    endcase
  endfunction

  logic tck_meta, tck_sync, tck_prev;
  logic tms_meta, tms_sync;
  logic tdi_meta, tdi_sync;
  logic tap_clk;

  tap_state_t state, next_state;
  logic [3:0]  ir, ir_shift;
  logic [31:0] dr_shift;
  logic        bypass_reg;
  logic        tdo;
  logic        sel_idcode, sel_user, sel_bypass;

  logic unused_pads;
  assign unused_pads = ^{mprj_io_in[37:18], mprj_io_in[14:0]};

  // Synchronizers idle high so that reset never fakes a TCK rising edge.
  always_ff @(posedge clock) begin
    if (!resetb) begin
      tck_meta <= 1'b1;
      tck_sync <= 1'b1;
      tck_prev <= 1'b1;
      tms_meta <= 1'b1;
      tms_sync <= 1'b1;
      tdi_meta <= 1'b1;
      tdi_sync <= 1'b1;
    end else begin
      tck_meta <= mprj_io_in[16];
      tck_sync <= tck_meta;
      tck_prev <= tck_sync;
      tms_meta <= mprj_io_in[15];
      tms_sync <= tms_meta;
      tdi_meta <= mprj_io_in[17];
      tdi_sync <= tdi_meta;
    end
  end

  assign tap_clk    = tck_sync & ~tck_prev;
  assign next_state = tap_next(state, tms_sync);

  assign sel_idcode = (ir == IR_IDCODE);
`ifdef CARAVEL_USER_DR_EN
  assign sel_user   = (ir == IR_USER);
`else
  assign sel_user   = 1'b0;
  assign user_reg   = '0;
`endif
  assign sel_bypass = ~sel_idcode & ~sel_user;

  always_ff @(posedge clock) begin
    if (!resetb) begin
      state      <= TLR;
      ir         <= IR_IDCODE;
      ir_shift   <= '0;
      dr_shift   <= '0;
      bypass_reg <= 1'b0;
      tdo        <= 1'b0;
`ifdef CARAVEL_USER_DR_EN
      user_reg   <= '0;
`endif
    end else if (tap_clk) begin
      state <= next_state;
      case (state)
        CAP_IR:   ir_shift <= IR_CAPTURE;
        SHIFT_IR: begin
          tdo      <= ir_shift[0];
          ir_shift <= {tdi_sync, ir_shift[3:1]};
        end
        UPD_IR:   ir <= ir_shift;
        CAP_DR: begin
          if (sel_bypass)
            bypass_reg <= 1'b0;
          else
            dr_shift <= sel_user ? user_reg : IDCODE;
        end
        SHIFT_DR: begin
          if (sel_bypass) begin
            tdo        <= bypass_reg;
            bypass_reg <= tdi_sync;
          end else begin
            tdo      <= dr_shift[0];
            dr_shift <= {tdi_sync, dr_shift[31:1]};
          end
        end
`ifdef CARAVEL_USER_DR_EN
        UPD_DR:   if (sel_user) user_reg <= dr_shift;
`endif
        default: ;
      endcase
      // Any path into Test-Logic-Reset reselects IDCODE; user_reg is left alone.
      if (next_state == TLR)
        ir <= IR_IDCODE;
    end
  end

  assign mprj_io_out = {23'd0, tdo, 14'd0};
  assign mprj_io_oeb = {23'h7FFFFF, 1'b0, 14'h3FFF};

endmodule

// File: tb/tb_caravel.sv
// Randomized JTAG scans against a bit-queue reference model of the caravel TAP.
module tb_caravel;

`ifdef CARAVEL_USER_DR_EN
  localparam bit USER_EN = 1'b1;
`else
  localparam bit USER_EN = 1'b0;
`endif
  localparam logic [31:0] IDCODE = 32'h14D57048;

  logic        clock = 1'b0;
  logic        resetb;
  logic        tck, tms, tdi;
  logic [37:0] noise;
  logic [37:0] pad_in, pad_out, pad_oeb;
  logic [31:0] user_reg;

  int vectors = 0;
  int miscompares = 0;

  logic [3:0]  model_ir;
  logic [31:0] model_user;
  logic        model_tdo;

  assign pad_in = {noise[37:18], tdi, tck, tms, noise[14:0]};

  caravel dut (
    .clock      (clock),
    .resetb     (resetb),
    .mprj_io_in (pad_in),
    .mprj_io_out(pad_out),
    .mprj_io_oeb(pad_oeb),
    .user_reg   (user_reg)
  );

  always #5 clock = ~clock;

  initial begin
    #3000000;
    $display("[TB] FAIL watchdog: simulation did not finish");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string tag, input logic [63:0] actual, input logic [63:0] expected);
    vectors++;
    if (actual !== expected) begin
      miscompares++;
      $display("[TB] FAIL %s: observed %h expected %h", tag, actual, expected);
    end
  endtask

  // One TAP clock: low phase with TMS/TDI set up, then rising TCK; TDO is sampled at the rise.
  task automatic applyStimulus(input logic tms_v, input logic tdi_v, output logic sampled);
    @(negedge clock);
    tck = 1'b0;
    tms = tms_v;
    tdi = tdi_v;
    repeat (6) @(negedge clock);
    tck = 1'b1;
    sampled = pad_out[14];
    repeat (6) @(negedge clock);
  endtask

  task automatic applyReset();
    @(negedge clock);
    tck = 1'b1; tms = 1'b1; tdi = 1'b1;
    resetb = 1'b0;
    repeat (2) @(negedge clock);
    resetb = 1'b1;
    repeat (2) @(negedge clock);
    model_ir   = 4'b0001;
    model_user = '0;
    model_tdo  = 1'b0;
  endtask

  task automatic checkPads();
    logic [37:0] exp_out;
    exp_out     = '0;
    exp_out[14] = model_tdo;
    checkOutput("pad_out", {26'd0, pad_out}, {26'd0, exp_out});
    checkOutput("pad_oeb", {26'd0, pad_oeb}, {26'd0, ~(38'd1 << 14)});
  endtask

  // Reference: the scan chain is the captured register followed by the TDI stream;
  // the first n bits come out, the last w bits stay behind in the register.
  task automatic modelDr(input int n, input logic [63:0] d, output logic [63:0] exp_out);
    bit          q[$];
    bit          is_user, is_id;
    int          w;
    logic [31:0] cap, remain;
    is_id   = (model_ir == 4'b0001);
    is_user = USER_EN && (model_ir == 4'b0010);
    w       = (is_id || is_user) ? 32 : 1;
    cap     = is_id ? IDCODE : (is_user ? model_user : 32'd0);
    for (int i = 0; i < w; i++) q.push_back(cap[i]);
    for (int i = 0; i < n; i++) q.push_back(d[i]);
    exp_out = '0;
    for (int i = 0; i < n; i++) exp_out[i] = q.pop_front();
    remain = '0;
    for (int i = 0; i < w; i++) remain[i] = q.pop_front();
    if (is_user) model_user = remain;
    model_tdo = exp_out[n-1];
  endtask

  // From Run-Test/Idle through a DR scan (optionally via Pause-DR) and back to Run-Test/Idle.
  task automatic scanDr(input int n, input logic [63:0] d, input int pause_at, output logic [63:0] got);
    logic s, last;
    bit   prev_shift;
    int   k;
    got = '0;
    k = 0;
    prev_shift = 1'b0;
    applyStimulus(1'b1, 1'b0, s);
    applyStimulus(1'b0, 1'b0, s);
    applyStimulus(1'b0, 1'b0, s);
    for (int i = 0; i < n; i++) begin
      last = (i == n-1) || (pause_at != 0 && i == pause_at-1);
      applyStimulus(last, d[i], s);
      if (prev_shift) begin got[k] = s; k++; end
      prev_shift = 1'b1;
      if (last && i != n-1) begin
        applyStimulus(1'b0, 1'b0, s);
        got[k] = s; k++;
        prev_shift = 1'b0;
        applyStimulus(1'b0, 1'b0, s);
        applyStimulus(1'b1, 1'b0, s);
        applyStimulus(1'b0, 1'b0, s);
      end
    end
    applyStimulus(1'b1, 1'b0, s);
    got[k] = s;
    applyStimulus(1'b0, 1'b0, s);
  endtask

  task automatic scanIr(input logic [3:0] d, output logic [3:0] got);
    logic s;
    got = '0;
    applyStimulus(1'b1, 1'b0, s);
    applyStimulus(1'b1, 1'b0, s);
    applyStimulus(1'b0, 1'b0, s);
    applyStimulus(1'b0, 1'b0, s);
    for (int i = 0; i < 4; i++) begin
      applyStimulus(i == 3, d[i], s);
      if (i > 0) got[i-1] = s;
    end
    applyStimulus(1'b1, 1'b0, s);
    got[3] = s;
    applyStimulus(1'b0, 1'b0, s);
  endtask

  task automatic doDr(input int n, input logic [63:0] d, input int pause_at);
    logic [63:0] got, exp_out, dm;
    dm = (n >= 64) ? d : (d & ((64'd1 << n) - 64'd1));
    scanDr(n, dm, pause_at, got);
    modelDr(n, dm, exp_out);
    checkOutput("dr_scan", got, exp_out);
    checkOutput("user_reg", {32'd0, user_reg}, {32'd0, model_user});
    checkPads();
  endtask

  task automatic doIr(input logic [3:0] d);
    logic [3:0] got;
    scanIr(d, got);
    checkOutput("ir_capture", {60'd0, got}, 64'h5);
    model_ir  = d;
    model_tdo = 1'b0;
    checkPads();
  endtask

  initial begin
    logic        s;
    logic [3:0]  ir_pick;
    int          n, p;
    logic [3:0]  ir_table [4];
    ir_table[0] = 4'b0001;
    ir_table[1] = 4'b1111;
    ir_table[2] = 4'b0010;
    ir_table[3] = 4'b0110;

    noise = {6'($urandom), $urandom};
    tck = 1'b1; tms = 1'b1; tdi = 1'b1; resetb = 1'b0;
    applyReset();
    checkPads();
    checkOutput("reset_user_reg", {32'd0, user_reg}, {32'd0, model_user});

    $display("[TB] IDCODE readback");
    applyStimulus(1'b0, 1'b1, s);
    doDr(32, 64'hFFFF_FFFF_FFFF_FFFF, 0);

    $display("[TB] bypass pattern and IR capture");
    doIr(4'b1111);
    doDr(4, 64'hD, 0);

    $display("[TB] USER register write and readback");
    doIr(4'b0010);
    doDr(32, 64'hDEADBEEF, 0);
    doDr(32, {32'd0, $urandom}, 0);

    $display("[TB] randomized scans");
    for (int it = 0; it < 24; it++) begin
      noise = {6'($urandom), $urandom};
      if ($urandom_range(0, 3) == 0) begin
        ir_pick = ir_table[$urandom_range(0, 3)];
        if ($urandom_range(0, 3) == 0) ir_pick = 4'($urandom);
        doIr(ir_pick);
      end else begin
        n = $urandom_range(1, 40);
        p = ($urandom_range(0, 2) == 0 && n > 2) ? $urandom_range(1, n-1) : 0;
        doDr(n, {$urandom, $urandom}, p);
      end
    end

    $display("[TB] five TMS=1 clocks from Shift-IR");
    doIr(4'b0010);
    doDr(32, {32'd0, $urandom}, 0);
    applyStimulus(1'b1, 1'b0, s);
    applyStimulus(1'b1, 1'b0, s);
    applyStimulus(1'b0, 1'b0, s);
    applyStimulus(1'b0, 1'b0, s);
    applyStimulus(1'b0, 1'($urandom), s);
    applyStimulus(1'b0, 1'($urandom), s);
    for (int i = 0; i < 5; i++) applyStimulus(1'b1, 1'($urandom), s);
    applyStimulus(1'b0, 1'b0, s);
    model_ir = 4'b0001;
    checkOutput("tlr_user_reg", {32'd0, user_reg}, {32'd0, model_user});
    doDr(32, {32'd0, $urandom}, 0);

    $display("[TB] reset in the middle of Shift-DR");
    doIr(4'b0010);
    doDr(32, 64'h1234_5679, 0);
    applyStimulus(1'b1, 1'b0, s);
    applyStimulus(1'b0, 1'b0, s);
    applyStimulus(1'b0, 1'b0, s);
    for (int i = 0; i < 5; i++) applyStimulus(1'b0, 1'($urandom), s);
    applyReset();
    checkPads();
    checkOutput("midshift_user_reg", {32'd0, user_reg}, {32'd0, model_user});
    applyStimulus(1'b0, 1'b0, s);
    doDr(32, {32'd0, $urandom}, 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/caravel.md
CARAVEL -- requirements
Module: caravel

Interface
REQ-001 SHALL provide ports: clock  input  1  system clock, all state on its rising edge.
REQ-002 SHALL provide ports: resetb  input  1  reset, synchronous, active-low.
REQ-003 SHALL provide ports: mprj_io_in  input  38  pad inputs; [15]=TMS, [16]=TCK, [17]=TDI.
REQ-004 SHALL provide ports: mprj_io_out  output  38  pad outputs; [14]=TDO, all other bits 0.
REQ-005 SHALL provide ports: mprj_io_oeb  output  38  active-low pad output enable; bit 14 = 0, all others 1.
REQ-006 SHALL provide ports: user_reg  output  32  USER data register contents (see Configuration).
REQ-007 SHALL fix parameter: IDCODE, default 32'h14D57048, value loaded into the DR by Capture-DR under the IDCODE instruction.

Function
REQ-008 SHALL pass TCK, TMS and TDI through 2-flop synchronizers on clock; a TCK event is a change in the synchronized TCK versus its previous-cycle value.
REQ-009 SHALL treat a synchronized 0->1 TCK change as a TAP clock, sampling synchronized TMS/TDI in that same clock cycle; falling TCK changes SHALL have no effect.
REQ-010 SHALL require TCK high and low phases of at least 4 clock periods each; faster TCK is unsupported.
REQ-011 SHALL implement the IEEE 1149.1 16-state TAP FSM (Test-Logic-Reset, Run-Test/Idle, Select/Capture/Shift/Exit1/Pause/Exit2/Update for DR and IR), advancing once per TAP clock on TMS; five TAP clocks with TMS=1 SHALL reach Test-Logic-Reset from any state.
REQ-012 SHALL use a 4-bit IR: 4'b0001 IDCODE, 4'b1111 BYPASS, 4'b0010 USER; every other code SHALL select BYPASS.
REQ-013 Capture-IR SHALL load 4'b0101 into the IR shift register; Shift-IR SHALL shift right with TDI entering the MSB; Update-IR SHALL copy the shift register to the IR.
REQ-014 Capture-DR SHALL load the selected 32-bit DR: IDCODE, user_reg, or for BYPASS a 1-bit register loaded with 0.
REQ-015 Shift-DR SHALL shift the selected DR right with TDI entering the MSB (bit 0 for BYPASS).
REQ-016 Update-DR under USER SHALL copy the DR shift register to user_reg.
REQ-017 On each TAP clock taken in Shift-DR or Shift-IR, a TDO register SHALL load the LSB of the active shift register before the shift.
REQ-018 TDO therefore SHALL lag by one TAP clock: the value present at the Nth shift rising edge is the bit shifted out at edge N-1.
REQ-019 In all other states the TDO register SHALL hold its value.
REQ-020 mprj_io_out[14] SHALL equal the TDO register.

Reset
REQ-021 With resetb=0 at a clock edge: TAP=Test-Logic-Reset, IR=IDCODE, DR and TDO register=0, user_reg=0, synchronizer and previous-TCK flops=1.
REQ-022 Reset SHALL create no TCK event while TCK idles high.
REQ-023 Entering Test-Logic-Reset SHALL set IR=IDCODE and leave user_reg unchanged.
REQ-024 Reset asserted mid-shift SHALL abort the shift with no Update.

Configuration
REQ-025 Macro CARAVEL_USER_DR_EN defined: USER instruction and user_reg behave as in REQ-012 to REQ-016.
REQ-026 Macro CARAVEL_USER_DR_EN undefined: code 4'b0010 SHALL select BYPASS, and user_reg SHALL be constant 0.

Verification
REQ-027 Reset, TCK/TMS/TDI=1, then TMS sequence 1,0,1,0,0 (TLR, RTI, Sel-DR, Cap-DR, Shift-DR), then 33 TAP clocks with TMS=0 and TDI=1 -> TDO sampled at rising TCK on the last 32 clocks, LSB-first, = 32'h14D57048.
REQ-028 Load IR=4'b1111, shift pattern 1,0,1,1 through DR -> TDO reproduces the pattern delayed by 2 TAP clocks; first bit out = 0.
REQ-029 Shift-IR after reset -> first two TDO bits = 1,0 (from capture value 0101).
REQ-030 With CARAVEL_USER_DR_EN: IR=0010, shift 32'hDEADBEEF, Update-DR -> user_reg=32'hDEADBEEF; a following Capture/Shift reads DEADBEEF back.
REQ-031 Without CARAVEL_USER_DR_EN: same sequence -> user_reg stays 0 and the DR behaves as 1-bit bypass.
REQ-032 Assert resetb=0 mid Shift-DR -> TAP=TLR, TDO=0, IR=IDCODE; mprj_io_oeb=all 1 except bit 14=0 throughout.
